// File: rtl/fft_frame_pacer.sv
// fft_frame_pacer
//   Takes complete FFT result frames as an AXI-Stream burst, parks them in a
//   two-bank (ping-pong) frame store and replays each stored frame as single
//   cycle o_valid strobes spaced PACE cycles apart. The FFT core cannot be
//   stalled, so a frame arriving while both banks are occupied is dropped and
//   counted, as is any frame whose length is not FRAME_LEN.
// Ports
//   i_clk          sole clock, rising edge
//   i_reset        asynchronous, active-high reset
//   s_axis_tdata   input sample
//   s_axis_tvalid  beat valid
//   s_axis_tlast   last beat of frame
//   s_axis_tready  constant 1
//   o_valid        single-cycle output strobe
//   o_data         output sample, held between strobes
//   o_sof          marks sample index 0 of a frame (with o_valid)
//   o_drop_count   dropped-frame count, saturating at 255
module fft_frame_pacer #(
  parameter int DATA_WIDTH = 17,
  parameter int FRAME_LEN  = 64,
  parameter int PACE       = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_sof,
  output logic [7:0]            o_drop_count
);

  localparam int IW = $clog2(FRAME_LEN);
  localparam int PW = $clog2(PACE);

  typedef enum logic [1:0] {W_SYNC, W_WRITE, W_DISCARD} wstate_t;
  typedef enum logic       {R_IDLE, R_PLAY}             rstate_t;

  wstate_t               wstate_q, wstate_d;
  rstate_t               rstate_q, rstate_d;
  logic [IW-1:0]         widx_q, widx_d;
  logic [IW-1:0]         ridx_q, ridx_d;
  logic                  wbank_q, wbank_d;
  logic                  rbank_q, rbank_d;
  logic [1:0]            full_q, full_d;
  logic [7:0]            drop_q, drop_d;
  logic [PW-1:0]         pace_q, pace_d;
  logic                  o_valid_q, o_valid_d;
  logic                  o_sof_q, o_sof_d;
  logic [DATA_WIDTH-1:0] o_data_q, o_data_d;

  logic [DATA_WIDTH-1:0] mem [2*FRAME_LEN];

  logic tick, beat, wr_en, wr_set, rd_issue, rd_clear, drop_inc;

  assign tick = (pace_q == PW'(PACE - 1));
  assign beat = s_axis_tvalid;

  // Write side
  always_comb begin
    wstate_d = wstate_q;
    widx_d   = widx_q;
    wbank_d  = wbank_q;
    wr_en    = 1'b0;
    wr_set   = 1'b0;
    drop_inc = 1'b0;
    unique case (wstate_q)
      W_SYNC: begin
        if (beat && s_axis_tlast) begin
          wstate_d = W_WRITE;
          widx_d   = '0;
        end
      end
      W_WRITE: begin
        if (beat) begin
          if (widx_q == '0 && full_q[wbank_q]) begin
            // Both banks busy: drop. A single-beat frame already carries its
            // own tlast, so only hunt for the end when it is still to come.
            drop_inc = 1'b1;
            if (!s_axis_tlast) wstate_d = W_DISCARD;
          end else begin
            wr_en = 1'b1;
            if (widx_q == IW'(FRAME_LEN - 1)) begin
              widx_d = '0;
              if (s_axis_tlast) begin
                wr_set  = 1'b1;
                wbank_d = ~wbank_q;
              end else begin
                drop_inc = 1'b1;
                wstate_d = W_DISCARD;
              end
            end else if (s_axis_tlast) begin
              drop_inc = 1'b1;
              widx_d   = '0;
            end else begin
              widx_d = widx_q + IW'(1);
            end
          end
        end
      end
      W_DISCARD: begin
        if (beat && s_axis_tlast) begin
          wstate_d = W_WRITE;
          widx_d   = '0;
        end
      end
      default: wstate_d = W_SYNC;
    endcase
  end

  // Read side; ridx_q is 0 whenever the reader is idle.
  always_comb begin
    rstate_d = rstate_q;
    ridx_d   = ridx_q;
    rbank_d  = rbank_q;
    rd_issue = 1'b0;
    rd_clear = 1'b0;
    unique case (rstate_q)
      R_IDLE: begin
        if (tick && full_q[rbank_q]) begin
          rd_issue = 1'b1;
          ridx_d   = IW'(1);
          rstate_d = R_PLAY;
        end
      end
      R_PLAY: begin
        if (tick) begin
          rd_issue = 1'b1;
          if (ridx_q == IW'(FRAME_LEN - 1)) begin
            rd_clear = 1'b1;
            rbank_d  = ~rbank_q;
            ridx_d   = '0;
            rstate_d = R_IDLE;
          end else begin
            ridx_d = ridx_q + IW'(1);
          end
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_comb begin
    full_d = full_q;
    if (rd_clear) full_d[rbank_q] = 1'b0;
    if (wr_set)   full_d[wbank_q] = 1'b1;
    drop_d    = (drop_inc && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
    pace_d    = tick ? '0 : pace_q + PW'(1);
    o_valid_d = rd_issue;
    o_sof_d   = rd_issue && (ridx_q == '0);
    o_data_d  = rd_issue ? mem[{rbank_q, ridx_q}] : o_data_q;
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[{wbank_q, widx_q}] <= s_axis_tdata;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wstate_q  <= W_SYNC;
      rstate_q  <= R_IDLE;
      widx_q    <= '0;
      ridx_q    <= '0;
      wbank_q   <= 1'b0;
      rbank_q   <= 1'b0;
      full_q    <= '0;
      drop_q    <= '0;
      pace_q    <= '0;
      o_valid_q <= 1'b0;
      o_sof_q   <= 1'b0;
      o_data_q  <= '0;
    end else begin
      wstate_q  <= wstate_d;
      rstate_q  <= rstate_d;
      widx_q    <= widx_d;
      ridx_q    <= ridx_d;
      wbank_q   <= wbank_d;
      rbank_q   <= rbank_d;
      full_q    <= full_d;
      drop_q    <= drop_d;
      pace_q    <= pace_d;
      o_valid_q <= o_valid_d;
      o_sof_q   <= o_sof_d;
      o_data_q  <= o_data_d;
    end
  end

  assign s_axis_tready = 1'b1;
  assign o_valid       = o_valid_q;
  assign o_sof         = o_sof_q;
  assign o_data        = o_data_q;
  assign o_drop_count  = drop_q;

endmodule

// File: doc/fft_frame_pacer.md
# fft_frame_pacer

Output-side companion to the FFT input repeating buffer: accepts complete FFT result frames as an AXI-Stream burst, holds them in a two-bank frame store, and replays each stored frame as sparse, evenly paced single-cycle `o_valid` strobes for slow downstream consumers such as the display/averaging path. It is the inverse of the input repeating buffer, converting a burst stream back to a paced sample stream. The FFT core cannot be back-pressured, so frames are dropped and counted whenever both banks are occupied.

## Interface
- `DATA_WIDTH`, 17: sample width in bits.
- `FRAME_LEN`, 64: samples per FFT frame; power of two, at least 4.
- `PACE`, 32: clock cycles between output strobes; at least 2.
- `i_clk`  in  1  sole clock; all logic is on the rising edge.
- `i_reset`  in  1  asynchronous, active-high reset.
- `s_axis_tdata`  in  DATA_WIDTH  FFT result sample.
- `s_axis_tvalid`  in  1  beat valid.
- `s_axis_tlast`  in  1  last beat of frame.
- `s_axis_tready`  out  1  tied to 1; the block never stalls.
- `o_valid`  out  1  single-cycle sample strobe.
- `o_data`  out  DATA_WIDTH  sample; holds its value between strobes.
- `o_sof`  out  1  high together with `o_valid` on sample index 0 of a frame.
- `o_drop_count`  out  8  frames discarded; saturates at 255.

## Operation
- Storage: two banks of `FRAME_LEN` x `DATA_WIDTH` with registered (1-cycle) read. Each bank has a `full` flag.
- The write FSM has three states: SYNC, WRITE and DISCARD.
  - SYNC, entered on reset: ignores beats until a beat with tlast, then goes to WRITE with index 0. The partial frame in flight at reset is lost and is not counted.
  - WRITE, index 0 beat: if `full[wbank]`, the beat is not written, `o_drop_count` increments, and the FSM goes to DISCARD. Otherwise the beat is written at index 0.
  - WRITE, other beats: each beat is written at the current index, then the index increments.
  - Frame completion: tlast at index `FRAME_LEN-1` sets `full[wbank]`, toggles `wbank` and resets the index to 0.
  - Malformed frame, either case below: `full` is not set, `o_drop_count` increments, and the bank is reused.
    - tlast at index below `FRAME_LEN-1`: the index resets to 0 and the FSM stays in WRITE.
    - index `FRAME_LEN-1` without tlast: the FSM goes to DISCARD.
  - DISCARD: ignores beats until tlast, then goes to WRITE with index 0. It does not count again.
- The read side has two states: IDLE and PLAY.
  - The free-running pace counter runs 0..`PACE-1` from reset. A tick occurs at `PACE-1`.
  - IDLE: on a tick with `full[rbank]`, the FSM issues a read of index 0 and goes to PLAY.
  - PLAY: each tick issues a read of the next index.
  - After the read of index `FRAME_LEN-1` is issued, `full[rbank]` clears, `rbank` toggles, and the FSM goes to IDLE.
  - The earliest restart is the next tick, so no gap beyond the normal pace is introduced.
- Banks are consumed in the order they were written (ping-pong). A frame is never partially overwritten while it is being read.

## Timing
- Reset values: `o_valid`=0, `o_data`=0, `o_sof`=0, `o_drop_count`=0, `s_axis_tready`=1. The pace counter is 0, both `full` flags are 0, `wbank`=`rbank`=0, and the write FSM is in SYNC.
- Latency: `o_valid` asserts exactly 1 cycle after the tick that issued the read.
- A complete frame is eligible for the first tick that occurs at least 1 cycle after its tlast beat.
- Output strobes are spaced exactly `PACE` cycles apart within a frame and across back-to-back frames.
- Same-edge set/clear on one bank: when the reader clears `full[b]` on the same edge the writer samples `full[b]` at index 0, the writer sees the pre-edge value (full) and drops the frame. The bank is free from the next cycle.
- A beat is accepted only when `s_axis_tvalid`=1. tlast with tvalid=0 is ignored.
- Asserting reset mid-frame clears all state immediately. Any output in progress stops, with `o_valid` low in the same cycle.

## Test plan
- Common bench settings: `FRAME_LEN`=8, `PACE`=4, one tlast-terminated sync beat after reset. Frame content is 1..8.
- Single frame, 8 contiguous beats: exactly 8 `o_valid` strobes 4 cycles apart with data 1..8. `o_sof` is high only on data=1. `o_drop_count`=0.
- Three back-to-back frames A, B, C while A is still playing: A and B play in order and C is dropped. `o_drop_count`=1 and no sample of C appears.
- Short frame, tlast at index 4: nothing is output for that frame and `o_drop_count`=1. The next good frame plays all 8 samples correctly.
- Overlong frame, 12 beats with tlast on beat 12: the frame is dropped once, `o_drop_count`=1, and the following good frame plays correctly.
- Reset asserted during playback at sample 3, then 2 good frames: `o_valid` drops at once and all outputs read 0. The first frame after release is consumed as sync, and the second plays 1..8.
- Saturation, 300 dropped frames: `o_drop_count` holds at 255.
